// File: rtl/floating_point_division_if.sv
// Handshake and operand/result bundle for the sequential binary32 divider.
interface floating_point_division_if;
  logic        start;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic        overflow;
  logic        underflow;
  logic        divide_by_zero;

  modport master (
    output start, input_a, input_b,
    input  busy, done, quotient, overflow, underflow, divide_by_zero
  );

  modport slave (
    input  start, input_a, input_b,
    output busy, done, quotient, overflow, underflow, divide_by_zero
  );
endinterface

// File: rtl/floating_point_division.sv
// Sequential binary32 divider: 25-step restoring mantissa division, truncating,
// simplified number model (hidden 1 always set, only all-zero words are zero).
module floating_point_division (
  input  logic                     clk,
  input  logic                     reset_n,
  floating_point_division_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_NORM   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [4:0]          r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_quotient;
  logic                r_overflow;
  logic                r_underflow;
  logic                r_divide_by_zero;

  logic                r_sign;
  logic                r_zero_a;
  logic                r_zero_b;
  logic signed [9:0]   r_exp_diff;
  logic [23:0]         r_mb;
  logic [24:0]         r_rem;
  logic [24:0]         r_q;

  logic                w_ge;
  logic [24:0]         w_rem_sub;
  logic [34:0]         w_result;

  // Packs {quotient, overflow, underflow, divide_by_zero} from the final quotient bits.
  function automatic logic [34:0] pack_result(
    input logic               sign,
    input logic               zero_a,
    input logic               zero_b,
    input logic signed [9:0]  exp_diff,
    input logic [24:0]        q
  );
    logic signed [9:0] e;
    logic [22:0]       m;
    e = q[24] ? exp_diff : exp_diff - 10'sd1;
    m = q[24] ? q[23:1] : q[22:0];
    if (zero_b)
      pack_result = {sign, 8'hFF, 23'h0, 3'b001};
    else if (zero_a)
      pack_result = {32'h0, 3'b000};
    else if (e > 10'sd254)
      pack_result = {sign, 8'hFF, 23'h0, 3'b100};
    else if (e < 10'sd1)
      pack_result = {sign, 31'h0, 3'b010};
    else
      pack_result = {sign, e[7:0], m, 3'b000};
  endfunction

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_state_next = S_DIVIDE;
      S_DIVIDE: if (r_cnt == 5'd0) w_state_next = S_NORM;
      S_NORM:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= 5'd0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_quotient       <= 32'h0;
      r_overflow       <= 1'b0;
      r_underflow      <= 1'b0;
      r_divide_by_zero <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            r_cnt  <= 5'd24;
          end
        end
        S_DIVIDE: r_cnt <= r_cnt - 5'd1;
        S_NORM: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          {r_quotient, r_overflow, r_underflow, r_divide_by_zero} <= w_result;
        end
        default: ;
      endcase
    end
  end

  // Remainder stays below twice the divisor, so the post-subtract value fits 24 bits.
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_result  = pack_result(r_sign, r_zero_a, r_zero_b, r_exp_diff, r_q);

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      r_sign     <= bus.input_a[31] ^ bus.input_b[31];
      r_zero_a   <= ~|bus.input_a;
      r_zero_b   <= ~|bus.input_b;
      r_exp_diff <= $signed({2'b00, bus.input_a[30:23]})
                  - $signed({2'b00, bus.input_b[30:23]}) + 10'sd127;
      r_mb       <= {1'b1, bus.input_b[22:0]};
      r_rem      <= {2'b01, bus.input_a[22:0]};
      r_q        <= 25'h0;
    end else if (r_state == S_DIVIDE) begin
      r_rem <= {w_rem_sub[23:0], 1'b0};
      r_q   <= {r_q[23:0], w_ge};
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.quotient       = r_quotient;
  assign bus.overflow       = r_overflow;
  assign bus.underflow      = r_underflow;
  assign bus.divide_by_zero = r_divide_by_zero;

endmodule
